month_day_counter: RTL

MONTH_DAY_COUNTER -- requirements
Module: month_day_counter

---
 rtl/month_day_counter_pkg.sv | 30 +++
 rtl/month_day_counter_days_in_month.sv | 20 ++
 rtl/month_day_counter.sv | 103 ++++++++++
 3 files changed

// File: rtl/month_day_counter_pkg.sv
// rtl/month_day_counter_pkg.sv - shared calendar constants and leap-year helper
package month_day_counter_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic FIELD_DAY   = 1'b0;
    localparam logic FIELD_MONTH = 1'b1;

    // Year range shared with the year counter.
    localparam logic [11:0] YEAR_MIN = 12'd2025;
    localparam logic [11:0] YEAR_MAX = 12'd3025;

    // Gregorian rule: every 4th year, except centuries not divisible by 400.
    function automatic logic is_leap(input logic [11:0] year);
        return ((year % 12'd4 == 12'd0) && (year % 12'd100 != 12'd0))
               || (year % 12'd400 == 12'd0);
    endfunction

endpackage

// File: rtl/month_day_counter_days_in_month.sv
// rtl/month_day_counter_days_in_month.sv - days-in-month table with leap February
import month_day_counter_pkg::*;

module days_in_month (
    input  logic [3:0]  month,
    input  logic [11:0] year,
    output logic [4:0]  dim
);

    // Table lookup; out-of-range months read as 31 (the recovery path handles them).
    always_comb begin
        dim = 5'd31;
        case (month)
            FEB:                dim = is_leap(year) ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: dim = 5'd30;
            default:            dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/month_day_counter.sv
// rtl/month_day_counter.sv - calendar day/month counter with set mode and year carry
import month_day_counter_pkg::*;

module month_day_counter #(
    parameter int RESET_DAY   = 1,
    parameter int RESET_MONTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_set,
    input  logic        sel_field,
    input  logic        inc,
    input  logic        dec,
    input  logic        carry_in_day,
    input  logic [11:0] year_count,
    output logic [4:0]  day_count,
    output logic [3:0]  month_count,
    output logic        carry_out_month
);

    logic [4:0] dim_cur;
    logic [4:0] dim_tgt;
    logic [3:0] month_up;
    logic [3:0] month_dn;
    logic [3:0] month_tgt;
    logic [4:0] day_clamped;
    logic       illegal;
    logic       step;

    logic [4:0] day_next;
    logic [3:0] month_next;
    logic       carry_next;

    // Length of the current month, used by run-mode rollover and day-field wraps.
    days_in_month u_dim_cur (
        .month (month_count),
        .year  (year_count),
        .dim   (dim_cur)
    );

    // Length of the month a set-mode month step would land on, for the same-edge clamp.
    days_in_month u_dim_tgt (
        .month (month_tgt),
        .year  (year_count),
        .dim   (dim_tgt)
    );

    // Neighbouring months with 12<->1 wrap; inc wins over dec.
    always_comb begin
        month_up    = (month_count >= DEC) ? JAN : month_count + 4'd1;
        month_dn    = (month_count <= JAN) ? DEC : month_count - 4'd1;
        month_tgt   = inc ? month_up : month_dn;
        day_clamped = (day_count > dim_cur) ? dim_cur : day_count;
        illegal     = (day_count == 5'd0) || (month_count == 4'd0) || (month_count > DEC);
        step        = inc || dec;
    end

    // Next-state selection: recovery, then set mode, then run-mode carry, else clamp.
    always_comb begin
        day_next   = day_clamped;
        month_next = month_count;
        carry_next = 1'b0;
        if (illegal) begin
            day_next   = 5'd1;
            month_next = JAN;
        end else if (ctrl_set) begin
            if (step && sel_field == FIELD_MONTH) begin
                month_next = month_tgt;
                day_next   = (day_count > dim_tgt) ? dim_tgt : day_count;
            end else if (step) begin
                if (inc) begin
                    day_next = (day_count >= dim_cur) ? 5'd1 : day_count + 5'd1;
                end else if (day_count <= 5'd1) begin
                    day_next = dim_cur;
                end else begin
                    day_next = (day_count - 5'd1 > dim_cur) ? dim_cur : day_count - 5'd1;
                end
            end
        end else if (carry_in_day) begin
            if (day_count < dim_cur) begin
                day_next = day_count + 5'd1;
            end else begin
                day_next   = 5'd1;
                month_next = month_up;
                carry_next = (month_count == DEC);
            end
        end
    end

    // Date and carry registers; reset also kills any pending year carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_count       <= 5'(RESET_DAY);
            month_count     <= 4'(RESET_MONTH);
            carry_out_month <= 1'b0;
        end else begin
            day_count       <= day_next;
            month_count     <= month_next;
            carry_out_month <= carry_next;
        end
    end

endmodule
